// File: rtl/debug_cmd_sequencer_if.sv
// UART transmit handshake between the command sequencer and a UART TX.
//   tx_data      : byte presented to the UART (held between sends)
//   tx_start     : one-cycle request to start sending tx_data
//   tx_done_tick : one-cycle pulse from the UART when the byte is on the line
// master = sequencer side, slave = UART side.
interface debug_cmd_sequencer_if #(
   parameter int unsigned NB_DATA = 8
) ();

   logic [NB_DATA-1:0] tx_data;
   logic               tx_start;
   logic               tx_done_tick;

   modport master (
      output tx_data,
      output tx_start,
      input  tx_done_tick
   );

   modport slave (
      input  tx_data,
      input  tx_start,
      output tx_done_tick
   );

endinterface

// File: rtl/debug_cmd_sequencer.sv
// Command player for the debug unit: stores up to 2**ADDR {command, pre-send delay}
// entries and replays them through a UART TX handshake, once or in a continuous loop.
//   i_clock, i_reset          : clock (rising edge), asynchronous active-low reset
//   i_push, i_cmd, i_delay    : append an entry while idle
//   i_clear                   : empty storage while idle (wins over a same-cycle push)
//   i_start, i_loop, i_abort  : playback control; i_loop is captured at start
//   uart                      : tx_data / tx_start / tx_done_tick handshake
//   o_busy, o_done            : playback active, end-of-pass pulse
//   o_push_err, o_full        : rejected-push pulse, storage full
//   o_count, o_index          : stored entries, entry being played
module debug_cmd_sequencer #(
   parameter int unsigned NB_DATA  = 8,
   parameter int unsigned NB_DELAY = 24,
   parameter int unsigned ADDR     = 3
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_push,
   input  logic [NB_DATA-1:0]    i_cmd,
   input  logic [NB_DELAY-1:0]   i_delay,
   input  logic                  i_clear,
   input  logic                  i_start,
   input  logic                  i_loop,
   input  logic                  i_abort,
   debug_cmd_sequencer_if.master uart,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_push_err,
   output logic                  o_full,
   output logic [ADDR:0]         o_count,
   output logic [ADDR-1:0]       o_index
);

   localparam int unsigned   DEPTH      = 2 ** ADDR;
   localparam logic [ADDR:0] FULL_COUNT = (ADDR + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StDelay, StStart, StWaitDone} state_e;

   // Storage is deliberately left out of reset; only count/pointers/state are reset.
   logic [NB_DATA-1:0]  cmd_mem [DEPTH];
   logic [NB_DELAY-1:0] dly_mem [DEPTH];

   state_e              state_q, state_d;
   logic [ADDR:0]       count_q, count_d;
   logic [ADDR-1:0]     index_q, index_d;
   logic [NB_DELAY-1:0] timer_q, timer_d;
   logic                loop_q, loop_d;
   logic [NB_DATA-1:0]  tx_data_q, tx_data_d;
   logic                tx_start_q, busy_q, done_q, push_err_q, full_q;
   logic                done_d, push_err_d, mem_we;
   logic [ADDR-1:0]     next_index;
   logic                last_entry;

   assign next_index = index_q + 1'b1;
   assign last_entry = ({1'b0, index_q} == (count_q - 1'b1));

   always_ff @(posedge i_clock) begin
      if (mem_we) begin
         cmd_mem[count_q[ADDR-1:0]] <= i_cmd;
         dly_mem[count_q[ADDR-1:0]] <= i_delay;
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      index_d    = index_q;
      timer_d    = timer_q;
      loop_d     = loop_q;
      tx_data_d  = tx_data_q;
      done_d     = 1'b0;
      push_err_d = 1'b0;
      mem_we     = 1'b0;

      // Abort beats every busy transition, so an abort coinciding with the
      // DELAY->START step never produces a tx_start pulse.
      if (state_q != StIdle && i_abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_start && count_q != '0) begin
                  index_d = '0;
                  timer_d = dly_mem[0];
                  loop_d  = i_loop;
                  state_d = StDelay;
               end else begin
                  done_d = i_start;
                  if (i_clear) begin
                     count_d = '0;
                  end else if (i_push) begin
                     if (count_q == FULL_COUNT) begin
                        push_err_d = 1'b1;
                     end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + 1'b1;
                     end
                  end
               end
            end
            StDelay: begin
               if (timer_q == '0) begin
                  tx_data_d = cmd_mem[index_q];
                  state_d   = StStart;
               end else begin
                  timer_d = timer_q - 1'b1;
               end
            end
            StStart: begin
               state_d = StWaitDone;
            end
            StWaitDone: begin
               if (uart.tx_done_tick) begin
                  if (!last_entry) begin
                     index_d = next_index;
                     timer_d = dly_mem[next_index];
                     state_d = StDelay;
                  end else if (loop_q) begin
                     index_d = '0;
                     timer_d = dly_mem[0];
                     state_d = StDelay;
                  end else begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Outputs are registered from next-state values so they line up with the state.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q    <= StIdle;
         count_q    <= '0;
         index_q    <= '0;
         timer_q    <= '0;
         loop_q     <= 1'b0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         push_err_q <= 1'b0;
         full_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         index_q    <= index_d;
         timer_q    <= timer_d;
         loop_q     <= loop_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= (state_d == StStart);
         busy_q     <= (state_d != StIdle);
         done_q     <= done_d;
         push_err_q <= push_err_d;
         full_q     <= (count_d == FULL_COUNT);
      end
   end

   assign uart.tx_data  = tx_data_q;
   assign uart.tx_start = tx_start_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_push_err    = push_err_q;
   assign o_full        = full_q;
   assign o_count       = count_q;
   assign o_index       = index_q;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Bench for debug_cmd_sequencer: directed stimulus, an event-timed reference model
// and a UART responder that returns tx_done_tick 10 cycles after each tx_start.
// Cycle numbering: "cycle n" is the clock period that ends at rising edge n.
module tb_debug_cmd_sequencer;

   localparam int NB_DATA  = 8;
   localparam int NB_DELAY = 24;
   localparam int ADDR     = 3;
   localparam int DEPTH    = 8;

   logic                clk   = 1'b0;
   logic                rst_n = 1'b1;
   logic                push  = 1'b0;
   logic                clear = 1'b0;
   logic                start = 1'b0;
   logic                loop  = 1'b0;
   logic                abort = 1'b0;
   logic                tick  = 1'b0;
   logic [NB_DATA-1:0]  cmd   = '0;
   logic [NB_DELAY-1:0] dly   = '0;
   logic                busy, done, perr, full;
   logic [ADDR:0]       count;
   logic [ADDR-1:0]     index;

   debug_cmd_sequencer_if #(.NB_DATA(NB_DATA)) uart ();
   assign uart.tx_done_tick = tick;

   debug_cmd_sequencer #(
      .NB_DATA (NB_DATA),
      .NB_DELAY(NB_DELAY),
      .ADDR    (ADDR)
   ) dut (
      .i_clock   (clk),
      .i_reset   (rst_n),
      .i_push    (push),
      .i_cmd     (cmd),
      .i_delay   (dly),
      .i_clear   (clear),
      .i_start   (start),
      .i_loop    (loop),
      .i_abort   (abort),
      .uart      (uart),
      .o_busy    (busy),
      .o_done    (done),
      .o_push_err(perr),
      .o_full    (full),
      .o_count   (count),
      .o_index   (index)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_bad  = 0;
   int cyc    = 0;
   bit chk_en = 0;

   // Reference model: tracks stored entries and the absolute edge of the next send.
   int         m_count = 0;
   logic [7:0] m_cmd [DEPTH];
   int         m_dly [DEPTH];
   bit         m_busy = 0, m_loop = 0, m_sent = 0;
   int         m_idx = 0, m_send_edge = 0, m_sent_edge = 0;
   logic [7:0] m_tx_data = 0;
   bit         m_tx_start = 0, m_done = 0, m_perr = 0;

   // UART responder and monitor records
   bit uart_en   = 0;
   bit stray     = 0;
   int tick_due  = -1;
   int perr_n    = 0;
   int send_cyc[$];
   int send_dat[$];
   int done_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
      end
   endtask

   task automatic schedule(input int e);
      m_sent      = 0;
      m_send_edge = e + 1 + m_dly[m_idx];
   endtask

   // One model step for inputs sampled at rising edge e.
   task automatic model_step(input int e);
      m_tx_start = 0;
      m_done     = 0;
      m_perr     = 0;
      if (m_busy) begin
         if (abort) begin
            m_busy = 0;
         end else if (!m_sent) begin
            if (e == m_send_edge) begin
               m_tx_start  = 1;
               m_tx_data   = m_cmd[m_idx];
               m_sent      = 1;
               m_sent_edge = e;
            end
         end else if (tick && e >= m_sent_edge + 2) begin
            // a tick in the same cycle as tx_start is not yet awaited
            if (m_idx < m_count - 1) begin
               m_idx++;
               schedule(e);
            end else if (m_loop) begin
               m_idx = 0;
               schedule(e);
            end else begin
               m_busy = 0;
               m_done = 1;
            end
         end
      end else if (start && m_count > 0) begin
         m_busy = 1;
         m_idx  = 0;
         m_loop = loop;
         schedule(e);
      end else begin
         if (start) m_done = 1;
         if (clear) begin
            m_count = 0;
         end else if (push) begin
            if (m_count == DEPTH) begin
               m_perr = 1;
            end else begin
               m_cmd[m_count] = cmd;
               m_dly[m_count] = int'(dly);
               m_count++;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_count    = 0;
         m_busy     = 0;
         m_loop     = 0;
         m_sent     = 0;
         m_idx      = 0;
         m_tx_data  = 0;
         m_tx_start = 0;
         m_done     = 0;
         m_perr     = 0;
      end else begin
         cyc = cyc + 1;
         model_step(cyc);
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      tick = (uart_en && (cyc + 1 == tick_due)) || stray;
   end

   // Compare every output against the model on every falling edge; also log events.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("push_err", 32'(perr), 32'(m_perr));
         chk("tx_start", 32'(uart.tx_start), 32'(m_tx_start));
         chk("tx_data", 32'(uart.tx_data), 32'(m_tx_data));
         chk("count", 32'(count), 32'(m_count));
         chk("full", 32'(full), 32'(m_count == DEPTH));
         chk("index", 32'(index), 32'(m_idx));
      end
      if (!rst_n) begin
         tick_due = -1;
      end else begin
         if (uart.tx_start === 1'b1) begin
            send_cyc.push_back(cyc + 1);
            send_dat.push_back(int'(uart.tx_data));
            tick_due = cyc + 1 + 10;
         end
         if (done === 1'b1) done_cyc.push_back(cyc + 1);
         if (perr === 1'b1) perr_n++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_push(input logic [7:0] c, input int d);
      push = 1;
      cmd  = c;
      dly  = NB_DELAY'(d);
      step();
      push = 0;
   endtask

   task automatic do_clear();
      clear = 1;
      step();
      clear = 0;
   endtask

   task automatic do_abort();
      abort = 1;
      step();
      abort = 0;
   endtask

   task automatic do_start(input bit lp, output int t);
      start = 1;
      loop  = lp;
      t     = cyc + 1;
      step();
      start = 0;
      loop  = 0;
   endtask

   task automatic wait_sends(input int n, input int budget);
      int k = 0;
      while (send_cyc.size() < n && k < budget) begin
         step();
         k++;
      end
      if (send_cyc.size() < n) chk("wait_sends_timeout", 32'(send_cyc.size()), 32'(n));
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         step();
         k++;
      end
      if (busy !== 1'b0) chk("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      int t, s, n, base;
      #2 rst_n = 0;
      chk_en = 1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      sample();
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_tx_data", 32'(uart.tx_data), 32'd0);

      // Three-entry single pass
      step();
      do_push(8'h01, 0);
      do_push(8'h07, 5);
      do_push(8'h08, 2);
      sample();
      chk("three_count", 32'(count), 32'd3);
      step();
      send_cyc.delete();
      send_dat.delete();
      done_cyc.delete();
      uart_en = 1;
      do_start(0, t);
      sample();
      chk("three_busy_t1", 32'(busy), 32'd1);
      wait_idle(200);
      sample();
      chk("three_nsend", 32'(send_cyc.size()), 32'd3);
      if (send_cyc.size() == 3) begin
         chk("three_send0_cyc", 32'(send_cyc[0] - t), 32'd2);
         chk("three_send1_cyc", 32'(send_cyc[1] - t), 32'd19);
         chk("three_send2_cyc", 32'(send_cyc[2] - t), 32'd33);
         chk("three_send0_dat", 32'(send_dat[0]), 32'h01);
         chk("three_send1_dat", 32'(send_dat[1]), 32'h07);
         chk("three_send2_dat", 32'(send_dat[2]), 32'h08);
      end
      chk("three_ndone", 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() == 1) chk("three_done_cyc", 32'(done_cyc[0] - t), 32'd44);

      // Overflow
      step();
      do_clear();
      for (int i = 0; i < DEPTH; i++) do_push(8'(8'h10 + i), 1);
      sample();
      chk("ovf_count", 32'(count), 32'd8);
      chk("ovf_full", 32'(full), 32'd1);
      base = perr_n;
      step();
      do_push(8'hFF, 0);
      sample();
      chk("ovf_perr_pulse", 32'(perr_n - base), 32'd1);
      chk("ovf_count_kept", 32'(count), 32'd8);
      step();
      do_clear();
      sample();
      chk("clear_count", 32'(count), 32'd0);
      chk("clear_full", 32'(full), 32'd0);

      // Loop then abort during DELAY
      step();
      do_push(8'h01, 3);
      do_push(8'h07, 3);
      send_cyc.delete();
      send_dat.delete();
      done_cyc.delete();
      do_start(1, t);
      wait_sends(4, 300);
      if (send_cyc.size() >= 4) begin
         chk("loop_d0", 32'(send_dat[0]), 32'h01);
         chk("loop_d1", 32'(send_dat[1]), 32'h07);
         chk("loop_d2", 32'(send_dat[2]), 32'h01);
         chk("loop_d3", 32'(send_dat[3]), 32'h07);
         chk("loop_first_cyc", 32'(send_cyc[0] - t), 32'd5);
         chk("loop_spacing", 32'(send_cyc[1] - send_cyc[0]), 32'd15);
         s = send_cyc[3];
         while (cyc + 1 < s + 12) step();
         do_abort();
         sample();
         chk("abort_busy", 32'(busy), 32'd0);
         n = send_cyc.size();
         repeat (40) step();
         chk("abort_no_send", 32'(send_cyc.size()), 32'(n));
      end
      chk("loop_no_done", 32'(done_cyc.size()), 32'd0);

      // Empty start
      step();
      do_clear();
      send_cyc.delete();
      done_cyc.delete();
      do_start(0, t);
      repeat (5) step();
      chk("empty_ndone", 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() == 1) chk("empty_done_cyc", 32'(done_cyc[0] - t), 32'd1);
      chk("empty_no_send", 32'(send_cyc.size()), 32'd0);

      // Reset during WAIT_DONE
      uart_en = 0;
      do_push(8'h05, 2);
      send_cyc.delete();
      do_start(0, t);
      wait_sends(1, 50);
      repeat (3) step();
      #1 rst_n = 0;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_start", 32'(uart.tx_start), 32'd0);
      chk("rst_tx_data", 32'(uart.tx_data), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_index", 32'(index), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      n = send_cyc.size();
      stray = 1;
      step();
      stray = 0;
      repeat (10) step();
      chk("stray_no_send", 32'(send_cyc.size()), 32'(n));

      // Push/clear rejected while busy
      do_push(8'h0A, 20);
      base = perr_n;
      do_start(0, t);
      step();
      do_push(8'h0B, 0);
      sample();
      chk("busy_push_count", 32'(count), 32'd1);
      chk("busy_push_noerr", 32'(perr_n - base), 32'd0);
      step();
      do_clear();
      sample();
      chk("busy_clear_count", 32'(count), 32'd1);
      step();
      do_abort();
      do_push(8'h0C, 0);
      sample();
      chk("idle_push_count", 32'(count), 32'd2);
      step();
      do_clear();
      sample();
      chk("idle_clear_count", 32'(count), 32'd0);
      chk("idle_clear_full", 32'(full), 32'd0);

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/debug_cmd_sequencer.md
# debug_cmd_sequencer

Synthesizable, parametrised command player that replaces hard-coded bench sequences of debug-unit commands (e.g. 0x01, then 0x07 after a long gap, then 0x08). It stores up to `2**ADDR` entries of {command byte, pre-send delay}. On start it replays them through a UART transmitter's `i_tx`/`i_tx_start`/`o_tx_done_tick` handshake, once or in a continuous loop. It sits between a host/scan loader and the `UART` TX side that feeds the debug unit's RX.

## Interface
Parameters:
- `NB_DATA`, 8: command byte width.
- `NB_DELAY`, 24: delay field width, in clock cycles.
- `ADDR`, 3: storage address width; depth `DEPTH = 2**ADDR`.

Ports:
- `i_clock`, in, 1: single clock, rising edge.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_push`, in, 1: append {`i_cmd`, `i_delay`} to storage.
- `i_cmd`, in, NB_DATA: command byte to store.
- `i_delay`, in, NB_DELAY: idle cycles before this command is sent.
- `i_clear`, in, 1: empty storage.
- `i_start`, in, 1: begin playback.
- `i_loop`, in, 1: repeat mode; sampled at start.
- `i_abort`, in, 1: stop playback.
- `i_tx_done_tick`, in, 1: UART byte-complete pulse.
- `o_tx_data`, out, NB_DATA: byte to UART `i_tx`.
- `o_tx_start`, out, 1: one-cycle pulse to UART `i_tx_start`.
- `o_busy`, out, 1: playback active.
- `o_done`, out, 1: one-cycle pulse at end of a non-loop pass.
- `o_push_err`, out, 1: one-cycle pulse when a push is rejected.
- `o_full`, out, 1: count == DEPTH.
- `o_count`, out, ADDR+1: number of stored entries.
- `o_index`, out, ADDR: entry currently being played.

## Operation
- States: IDLE, DELAY, START, WAIT_DONE. All outputs are registered.
- **IDLE:**
  - `i_push` with count < DEPTH: write the entry at `count`, then count+1.
  - `i_push` with count == DEPTH: ignored; `o_push_err` pulses.
  - `i_clear`: count ← 0. If `i_clear` and `i_push` arrive in the same cycle, clear wins.
  - `i_start` with count > 0: index ← 0, timer ← delay[0], loop flag ← `i_loop`, go to DELAY.
  - `i_start` with count == 0: `o_done` pulses next cycle; stay in IDLE.
- **DELAY:** if timer == 0, go to START; else timer−1. The state therefore lasts delay+1 cycles.
- **START:** `o_tx_start` = 1 for exactly one cycle. `o_tx_data` ← cmd[index] and stays held until the next START. Go to WAIT_DONE.
- **WAIT_DONE:** wait for `i_tx_done_tick`. On the tick:
  - index < count−1: index+1, load the next delay, go to DELAY.
  - Last entry with loop flag set: index ← 0, load delay[0], go to DELAY.
  - Last entry otherwise: `o_done` pulses, go to IDLE.
- **While busy (`o_busy` = 1 in DELAY, START, WAIT_DONE):**
  - `i_push`, `i_clear` and `i_start` are ignored. A rejected push in this case does not raise `o_push_err`.
  - `i_tx_done_tick` outside WAIT_DONE is ignored.
- **Abort:** `i_abort` in any busy state returns to IDLE next cycle with no `o_done`. If the abort lands in START, `o_tx_start` is suppressed. An in-flight UART byte completes on the line; its done tick is ignored.
- Storage array is not reset. Only count, pointers and state are.
- Delay arithmetic is unsigned, with no wrap: the timer saturates at 0.

## Timing
- **Reset values:** `o_tx_data` = 0, `o_tx_start` = 0, `o_busy` = 0, `o_done` = 0, `o_push_err` = 0, `o_full` = 0, `o_count` = 0, `o_index` = 0, state IDLE.
- Asserting `i_reset` clears all of the above immediately, including mid-playback.
- **First send:** with `i_start` sampled at edge t, `o_busy` = 1 from t+1 and `o_tx_start` is high in cycle t+2+delay[0].
- **Subsequent sends:** with `i_tx_done_tick` sampled at edge u, the next `o_tx_start` is high in cycle u+2+delay[next].
- **End of pass:** `o_done` is high in cycle u+1 after the last tick, and `o_busy` = 0 in the same cycle.
- **Push:** a push at edge t updates `o_count` and `o_full` at t+1.

## Test plan
- **Three-entry pass:** load (0x01,0), (0x07,5), (0x08,2); start at t; UART model returns its tick 10 cycles after each `o_tx_start`.
  - Required: `o_tx_start` at t+2 (data 0x01), at t+2+10+7 (0x07), then +10+4 (0x08).
  - `o_done` is a single pulse one cycle after the third tick; `o_busy` falls with it.
- **Overflow:** push 8 entries with ADDR=3 → `o_full` = 1, `o_count` = 8. A 9th push → `o_push_err` pulse, count stays 8.
- **Loop and abort:** loop mode with (0x01,3), (0x07,3) → pattern 0x01, 0x07, 0x01, … with no `o_done`. `i_abort` during DELAY → `o_busy` = 0 next cycle and no further `o_tx_start`.
- **Empty start:** `i_start` with count 0 → `o_done` pulse at t+1; `o_tx_start` never asserts.
- **Reset mid-operation:** assert `i_reset` low during WAIT_DONE → all outputs 0 immediately and count 0. After release, a stray `i_tx_done_tick` produces no `o_tx_start`.
- **Busy rejection and clear:** `i_push` while busy → count unchanged, no `o_push_err`. `i_clear` in IDLE → `o_count` = 0 and `o_full` = 0 next cycle.
